// File: rtl/requant_pkg.sv
// rtl/requant_pkg.sv - rounding mode encoding and parameter legality check for requant_sat
package requant_pkg;

   typedef enum logic [1:0] {
      RND_TRUNC     = 2'd0,
      RND_HALF_UP   = 2'd1,
      RND_HALF_EVEN = 2'd2,
      RND_RSVD      = 2'd3
   } round_mode_e;

   // Only narrowing of the fraction and of the integer part is supported.
   function automatic bit requant_params_legal(input int in_w, input int in_f,
                                               input int out_w, input int out_f);
      return (in_f >= out_f) && ((in_w - in_f) >= (out_w - out_f));
   endfunction

endpackage

// File: rtl/requant_lane.sv
// rtl/requant_lane.sv - one lane of the requantiser: S1 round, S2 saturate
// Both stages load only when the shared adv enable is high.
module requant_lane
   import requant_pkg::*;
#(
   parameter int IN_W  = 16,
   parameter int IN_F  = 12,
   parameter int OUT_W = 12,
   parameter int OUT_F = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             adv,
   input  logic [1:0]       mode,
   input  logic [IN_W-1:0]  x,
   output logic [OUT_W-1:0] y,
   output logic             sat
);

   localparam int D  = IN_F - OUT_F;
   localparam int RW = IN_W + 1 - D;
   localparam logic signed [RW-1:0] MAXV = RW'((2 ** (OUT_W - 1)) - 1);
   localparam logic signed [RW-1:0] MINV = RW'(-(2 ** (OUT_W - 1)));
   localparam logic [OUT_W-1:0] YMAX = {1'b0, {(OUT_W - 1){1'b1}}};
   localparam logic [OUT_W-1:0] YMIN = {1'b1, {(OUT_W - 1){1'b0}}};

   logic signed [RW-1:0] r_next;
   logic signed [RW-1:0] r1;
   logic [OUT_W-1:0]     y_next;
   logic                 sat_next;

   generate
      if (D == 0) begin : g_pass
         logic unused_mode;
         assign unused_mode = ^mode;
         assign r_next = $signed({x[IN_W-1], x});
      end else begin : g_round
         round_mode_e       m;
         logic [IN_W:0]     half;
         logic [IN_W:0]     bias;
         logic [IN_W:0]     sum;
         assign m = round_mode_e'(mode);
         always_comb begin
            half       = '0;
            half[D-1]  = 1'b1;
            bias       = '0;
            case (m)
               RND_HALF_UP:   bias = half;
               RND_HALF_EVEN: bias = half - 1'b1 + {{IN_W{1'b0}}, x[D]};
               default:       bias = '0;
            endcase
            // One guard bit above the input keeps the rounding carry from wrapping.
            sum = {x[IN_W-1], x} + bias;
         end
         assign r_next = $signed(sum[IN_W:D]);
      end
   endgenerate

   always_comb begin
      y_next   = r1[OUT_W-1:0];
      sat_next = 1'b0;
      if (r1 > MAXV) begin
         y_next   = YMAX;
         sat_next = 1'b1;
      end else if (r1 < MINV) begin
         y_next   = YMIN;
         sat_next = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r1  <= '0;
         y   <= '0;
         sat <= 1'b0;
      end else if (adv) begin
         r1  <= r_next;
         y   <= y_next;
         sat <= sat_next;
      end
   end

endmodule

// File: rtl/requant_sat.sv
// rtl/requant_sat.sv - multi-lane pipelined requantiser with saturation and stream handshake
// Optional saturated-beat counter built only when REQUANT_SAT_STATS_EN is defined.
module requant_sat
   import requant_pkg::*;
#(
   parameter int LANES = 4,
   parameter int IN_W  = 16,
   parameter int IN_F  = 12,
   parameter int OUT_W = 12,
   parameter int OUT_F = 10,
   parameter int CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [1:0]             mode,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [LANES*IN_W-1:0]  in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [LANES*OUT_W-1:0] out_data,
   output logic [LANES-1:0]       out_sat,
   input  logic                   clr_count,
   output logic [CNT_W-1:0]       sat_count
);

   generate
      if (!requant_params_legal(IN_W, IN_F, OUT_W, OUT_F)) begin : g_bad_params
         $error("requant_sat: illegal IN/OUT format parameters");
      end
   endgenerate

   logic adv;
   logic v1;

   // The whole pipeline stalls together, so a beat never overtakes or drops another.
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1        <= 1'b0;
         out_valid <= 1'b0;
      end else if (adv) begin
         v1        <= in_valid;
         out_valid <= v1;
      end
   end

   generate
      for (genvar i = 0; i < LANES; i++) begin : g_lane
         requant_lane #(
            .IN_W  (IN_W),
            .IN_F  (IN_F),
            .OUT_W (OUT_W),
            .OUT_F (OUT_F)
         ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .adv   (adv),
            .mode  (mode),
            .x     (in_data[i*IN_W +: IN_W]),
            .y     (out_data[i*OUT_W +: OUT_W]),
            .sat   (out_sat[i])
         );
      end
   endgenerate

`ifdef REQUANT_SAT_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sat_count <= '0;
      end else if (clr_count) begin
         sat_count <= '0;
      end else if (out_valid && out_ready && (|out_sat) && (sat_count != {CNT_W{1'b1}})) begin
         sat_count <= sat_count + 1'b1;
      end
   end
`else
   logic unused_clr;
   assign unused_clr = clr_count;
   assign sat_count  = '0;
`endif

endmodule

// File: tb/tb_requant_sat.sv
// tb/tb_requant_sat.sv - randomized and directed self-checking bench for requant_sat
// Reference model works in plain integer arithmetic (floor division and clamping).
module tb_requant_sat;

   localparam int LANES = 4;
   localparam int IN_W  = 16;
   localparam int IN_F  = 12;
   localparam int OUT_W = 12;
   localparam int OUT_F = 10;
   localparam int CNT_W = 4;
   localparam int SC    = 1 << (IN_F - OUT_F);
   localparam int OMAX  = (1 << (OUT_W - 1)) - 1;
   localparam int OMIN  = -(1 << (OUT_W - 1));
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic [1:0]             mode;
   logic                   in_valid;
   logic                   in_ready;
   logic [LANES*IN_W-1:0]  in_data;
   logic                   out_valid;
   logic                   out_ready;
   logic [LANES*OUT_W-1:0] out_data;
   logic [LANES-1:0]       out_sat;
   logic                   clr_count;
   logic [CNT_W-1:0]       sat_count;

   requant_sat #(
      .LANES (LANES), .IN_W (IN_W), .IN_F (IN_F),
      .OUT_W (OUT_W), .OUT_F (OUT_F), .CNT_W (CNT_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode      (mode),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sat   (out_sat),
      .clr_count (clr_count),
      .sat_count (sat_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [LANES*OUT_W-1:0] d;
      logic [LANES-1:0]       s;
   } beat_t;

   beat_t                  exp_q[$];
   int                     checks   = 0;
   int                     failures = 0;
   int                     exp_cnt  = 0;
   int                     n_acc    = 0;
   int                     n_out    = 0;
   bit                     prev_stalled = 0;
   logic [LANES*OUT_W-1:0] prev_data;
   logic [LANES-1:0]       prev_sat;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void model(input logic [IN_W-1:0] xv, input logic [1:0] m,
                                 output int y, output bit s);
      int x, q, rem;
      x   = $signed(xv);
      q   = (x >= 0) ? x / SC : -((-x + SC - 1) / SC);
      rem = x - q * SC;
      if (m == 2'd1 && rem >= SC / 2) q++;
      if (m == 2'd2 && (rem > SC / 2 || (rem == SC / 2 && (q & 1) != 0))) q++;
      y = (q > OMAX) ? OMAX : (q < OMIN) ? OMIN : q;
      s = (y != q);
   endfunction

   function automatic beat_t predict(input logic [LANES*IN_W-1:0] din, input logic [1:0] m);
      beat_t b;
      int    y;
      bit    s;
      for (int i = 0; i < LANES; i++) begin
         model(din[i*IN_W +: IN_W], m, y, s);
         b.d[i*OUT_W +: OUT_W] = y[OUT_W-1:0];
         b.s[i]                = s;
      end
      return b;
   endfunction

   // One clock: inputs were set at the preceding negedge; sample mid-cycle, then move on.
   task automatic step();
      beat_t e;
      bit    hs_sat;
      #2;
      hs_sat = 0;
      if (prev_stalled) begin
         check("hold_valid", out_valid, 1);
         check("hold_data", out_data, prev_data);
         check("hold_sat", out_sat, prev_sat);
      end
      if (out_valid && !out_ready) check("stall_in_ready", in_ready, 0);
      check("sat_count", sat_count, exp_cnt);
      if (out_valid && out_ready) begin
         n_out++;
         if (exp_q.size() == 0) begin
            check("spurious_out", exp_q.size(), 1);
         end else begin
            e = exp_q.pop_front();
            check("out_data", out_data, e.d);
            check("out_sat", out_sat, e.s);
            hs_sat = |e.s;
         end
      end
      if (in_valid && in_ready) begin
         exp_q.push_back(predict(in_data, mode));
         n_acc++;
      end
`ifdef REQUANT_SAT_STATS_EN
      if (clr_count) exp_cnt = 0;
      else if (hs_sat && exp_cnt != CMAX) exp_cnt++;
`endif
      prev_stalled = out_valid && !out_ready;
      prev_data    = out_data;
      prev_sat     = out_sat;
      @(negedge clk);
   endtask

   task automatic drain();
      int k;
      in_valid  = 0;
      out_ready = 1;
      clr_count = 0;
      k = 0;
      while ((exp_q.size() != 0 || out_valid) && k < 20) begin
         step();
         k++;
      end
      check("drain_empty", exp_q.size(), 0);
   endtask

   task automatic directed(input int x, input logic [1:0] m, input int ey, input bit es);
      int  lat;
      logic [IN_W-1:0] xv;
      xv        = x[IN_W-1:0];
      in_data   = {LANES{xv}};
      mode      = m;
      in_valid  = 1;
      out_ready = 1;
      step();
      in_valid = 0;
      lat      = 0;
      for (int k = 1; k <= 6 && lat == 0; k++) begin
         #1;
         if (out_valid) begin
            lat = k;
            check("dir_lane0", $signed(out_data[0 +: OUT_W]), ey);
            check("dir_lane3", $signed(out_data[3*OUT_W +: OUT_W]), ey);
            check("dir_sat", out_sat, es ? {LANES{1'b1}} : '0);
         end
         step();
      end
      check("dir_latency", lat, 2);
   endtask

   function automatic logic [IN_W-1:0] rand_word();
      int v;
      case ($urandom % 4)
         0:       v = $urandom;
         1:       v = $urandom_range(0, 127) - 64;
         2:       v = 8180 + $urandom_range(0, 15);
         default: v = -8200 + $urandom_range(0, 15);
      endcase
      return v[IN_W-1:0];
   endfunction

   int dx[15] = '{32767, 32767, -32768, 8188, 6, 6, 6, 10, 10, 10, -6, -6, -6, 8190, 8190};
   int dm[15] = '{0, 1, 2, 1, 0, 1, 2, 0, 1, 2, 0, 1, 2, 1, 0};
   int dy[15] = '{2047, 2047, -2048, 2047, 1, 2, 2, 2, 3, 2, -2, -1, -2, 2047, 2047};
   bit ds[15] = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int base_acc, base_out, k;
      rst_n     = 0;
      mode      = 0;
      in_valid  = 0;
      in_data   = '0;
      out_ready = 1;
      clr_count = 0;
      repeat (3) @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_sat", out_sat, 0);
      check("rst_sat_count", sat_count, 0);
      rst_n = 1;
      @(negedge clk);

      for (int i = 0; i < 15; i++) begin
         directed(dx[i], dm[i][1:0], dy[i], ds[i]);
         drain();
      end

      // 20-beat stream with a 5-cycle downstream stall in the middle.
      base_acc = n_acc;
      base_out = n_out;
      k = 0;
      while (n_acc - base_acc < 20 && k < 200) begin
         in_valid  = 1;
         in_data   = {rand_word(), rand_word(), rand_word(), rand_word()};
         mode      = 2'($urandom);
         out_ready = !(k >= 6 && k < 11);
         step();
         k++;
      end
      drain();
      check("stream_beats_out", n_out - base_out, 20);

      // Randomized traffic with random backpressure and counter clears.
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom % 4) != 0;
         in_data   = {rand_word(), rand_word(), rand_word(), rand_word()};
         mode      = 2'($urandom);
         out_ready = ($urandom % 3) != 0;
         clr_count = ($urandom % 16) == 0;
         step();
      end
      drain();

`ifdef REQUANT_SAT_STATS_EN
      clr_count = 1;
      step();
      clr_count = 0;
      for (int i = 0; i < 3; i++) directed(32767, 2'd0, 2047, 1);
      drain();
      #1 check("stats_three", sat_count, 3);
      in_data  = {LANES{16'h7fff}};
      in_valid = 1;
      step();
      in_valid = 0;
      k = 0;
      while (k < 6) begin
         #1;
         if (out_valid) break;
         step();
         k++;
      end
      clr_count = 1;
      step();
      clr_count = 0;
      #1 check("stats_clr_wins", sat_count, 0);
      drain();
      for (int i = 0; i < 20; i++) begin
         in_data  = {LANES{16'h8000}};
         in_valid = 1;
         step();
      end
      drain();
      #1 check("stats_sticky", sat_count, CMAX);
`endif

      // Reset with two beats in flight.
      in_valid  = 1;
      out_ready = 1;
      in_data   = {LANES{16'h7fff}};
      step();
      in_data = {LANES{16'h0123}};
      step();
      in_valid = 0;
      #1;
      rst_n = 0;
      #1;
      check("rst_fly_valid", out_valid, 0);
      check("rst_fly_data", out_data, 0);
      check("rst_fly_sat", out_sat, 0);
      check("rst_fly_count", sat_count, 0);
      exp_q.delete();
      exp_cnt      = 0;
      prev_stalled = 0;
      repeat (2) @(negedge clk);
      rst_n    = 1;
      base_out = n_out;
      for (int i = 0; i < 6; i++) step();
      check("no_stale_beat", n_out - base_out, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
